// File: rtl/morse_keyer_if.sv
// Character source <-> Morse keyer signal bundle.
// The keyer is the slave; the switch/character source is the master.
interface morse_keyer_if;
    logic [5:0] char_code;
    logic       start;
    logic       repeat_en;
    logic       key_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] sym_len;
    logic [5:0] pattern;

    modport master (
        output char_code, start, repeat_en,
        input  key_out, busy, done, err, sym_len, pattern
    );

    modport slave (
        input  char_code, start, repeat_en,
        output key_out, busy, done, err, sym_len, pattern
    );
endinterface

// File: rtl/morse_keyer.sv
// Morse keyer: latches a 6-bit character code and serialises its ITU Morse
// pattern onto key_out with dot/dash/gap timing in units of UNIT_CYCLES clocks.
module morse_keyer #(
    parameter int unsigned UNIT_CYCLES = 12_500_000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    morse_keyer_if.slave key_if
);
    localparam int unsigned CntW = $clog2(UNIT_CYCLES + 1);
    localparam logic [CntW-1:0] UnitMax = CntW'(UNIT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StMark, StSpace, StCgap, StWgap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] unit_cnt_q, unit_cnt_d;
    logic [1:0]      units_q, units_d;
    logic [2:0]      idx_q, idx_d;
    logic [5:0]      pattern_q, pattern_d;
    logic [2:0]      sym_len_q, sym_len_d;
    logic            key_out_q, key_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [8:0]      rom_entry;  // {length, pattern}; length 0 marks an invalid code
    logic            rom_valid;
    logic            tick;
    logic            cur_dash;
    logic [1:0]      state_last;  // final units_q value for the current state
    logic            last_unit;

    // Character ROM: code -> {symbol count, MSB-first dash pattern}
    always_comb begin
        rom_entry = 9'd0;
        unique case (key_if.char_code)
            6'd1:  rom_entry = {3'd2, 6'b010000};  // A
            6'd2:  rom_entry = {3'd4, 6'b100000};  // B
            6'd3:  rom_entry = {3'd4, 6'b101000};  // C
            6'd4:  rom_entry = {3'd3, 6'b100000};  // D
            6'd5:  rom_entry = {3'd1, 6'b000000};  // E
            6'd6:  rom_entry = {3'd4, 6'b001000};  // F
            6'd7:  rom_entry = {3'd3, 6'b110000};  // G
            6'd8:  rom_entry = {3'd4, 6'b000000};  // H
            6'd9:  rom_entry = {3'd2, 6'b000000};  // I
            6'd10: rom_entry = {3'd4, 6'b011100};  // J
            6'd11: rom_entry = {3'd3, 6'b101000};  // K
            6'd12: rom_entry = {3'd4, 6'b010000};  // L
            6'd13: rom_entry = {3'd2, 6'b110000};  // M
            6'd14: rom_entry = {3'd2, 6'b100000};  // N
            6'd15: rom_entry = {3'd3, 6'b111000};  // O
            6'd16: rom_entry = {3'd4, 6'b011000};  // P
            6'd17: rom_entry = {3'd4, 6'b110100};  // Q
            6'd18: rom_entry = {3'd3, 6'b010000};  // R
            6'd19: rom_entry = {3'd3, 6'b000000};  // S
            6'd20: rom_entry = {3'd1, 6'b100000};  // T
            6'd21: rom_entry = {3'd3, 6'b001000};  // U
            6'd22: rom_entry = {3'd4, 6'b000100};  // V
            6'd23: rom_entry = {3'd3, 6'b011000};  // W
            6'd24: rom_entry = {3'd4, 6'b100100};  // X
            6'd25: rom_entry = {3'd4, 6'b101100};  // Y
            6'd26: rom_entry = {3'd4, 6'b110000};  // Z
            6'd27: rom_entry = {3'd5, 6'b111110};  // 0
            6'd28: rom_entry = {3'd5, 6'b011110};  // 1
            6'd29: rom_entry = {3'd5, 6'b001110};  // 2
            6'd30: rom_entry = {3'd5, 6'b000110};  // 3
            6'd31: rom_entry = {3'd5, 6'b000010};  // 4
            6'd32: rom_entry = {3'd5, 6'b000000};  // 5
            6'd33: rom_entry = {3'd5, 6'b100000};  // 6
            6'd34: rom_entry = {3'd5, 6'b110000};  // 7
            6'd35: rom_entry = {3'd5, 6'b111000};  // 8
            6'd36: rom_entry = {3'd5, 6'b111100};  // 9
            6'd37: rom_entry = {3'd6, 6'b010101};  // .
            6'd38: rom_entry = {3'd6, 6'b110011};  // ,
            6'd39: rom_entry = {3'd6, 6'b001100};  // ?
            default: rom_entry = 9'd0;
        endcase
    end

    assign rom_valid = (rom_entry[8:6] != 3'd0);
    assign tick      = (unit_cnt_q == UnitMax);
    assign cur_dash  = pattern_q[3'd5 - idx_q];

    // Duration of the current state in units, minus one
    always_comb begin
        state_last = 2'd0;
        unique case (state_q)
            StMark:  state_last = cur_dash ? 2'd2 : 2'd0;
            StSpace: state_last = 2'd0;
            StCgap:  state_last = 2'd2;
            StWgap:  state_last = 2'd3;  // 3 units of CGAP + 4 here = 7-unit word gap
            default: state_last = 2'd0;
        endcase
    end

    assign last_unit = tick && (units_q == state_last);

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            unit_cnt_q <= '0;
            units_q    <= 2'd0;
            idx_q      <= 3'd0;
            pattern_q  <= 6'd0;
            sym_len_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            unit_cnt_q <= unit_cnt_d;
            units_q    <= units_d;
            idx_q      <= idx_d;
            pattern_q  <= pattern_d;
            sym_len_q  <= sym_len_d;
        end
    end

    // Next-state logic: unit timing, symbol sequencing and character latch
    always_comb begin
        state_d    = state_q;
        unit_cnt_d = unit_cnt_q;
        units_d    = units_q;
        idx_d      = idx_q;
        pattern_d  = pattern_q;
        sym_len_d  = sym_len_q;

        if (state_q == StIdle) begin
            unit_cnt_d = '0;
            units_d    = 2'd0;
            if (key_if.start && rom_valid) begin
                pattern_d = rom_entry[5:0];
                sym_len_d = rom_entry[8:6];
                idx_d     = 3'd0;
                state_d   = StMark;
            end
        end else if (last_unit) begin
            unit_cnt_d = '0;
            units_d    = 2'd0;
            unique case (state_q)
                StMark:  state_d = (idx_q != sym_len_q - 3'd1) ? StSpace : StCgap;
                StSpace: begin
                    idx_d   = idx_q + 3'd1;
                    state_d = StMark;
                end
                StCgap:  state_d = key_if.repeat_en ? StWgap : StIdle;
                StWgap:  begin
                    idx_d   = 3'd0;
                    state_d = StMark;
                end
                default: state_d = StIdle;
            endcase
        end else if (tick) begin
            unit_cnt_d = '0;
            units_d    = units_q + 2'd1;
        end else begin
            unit_cnt_d = unit_cnt_q + 1'b1;
        end
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        key_out_d = (state_d == StMark);
        busy_d    = (state_d != StIdle);
        done_d    = (state_q == StCgap) && (state_d == StIdle);
        err_d     = (state_q == StIdle) && key_if.start && !rom_valid;
    end

    // Output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            key_out_q <= key_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign key_if.key_out = key_out_q;
    assign key_if.busy    = busy_q;
    assign key_if.done    = done_q;
    assign key_if.err     = err_q;
    assign key_if.sym_len = sym_len_q;
    assign key_if.pattern = pattern_q;
endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with UNIT_CYCLES = 4.
module tb_morse_keyer;
    localparam int unsigned U = 4;

    logic clk_i = 1'b0;
    logic rst_i;

    morse_keyer_if key_if ();

    morse_keyer #(.UNIT_CYCLES(U)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .key_if (key_if)
    );

    always #5 clk_i = ~clk_i;

    int   checks   = 0;
    int   failures = 0;
    logic cap_key[$];
    logic cap_busy[$];
    logic cap_done[$];
    logic exp_key[$];

    task automatic push_seg(input logic v, input int n);
        for (int k = 0; k < n; k++) exp_key.push_back(v);
    endtask

    // Present start for one rising edge; returns at the negedge after that edge
    task automatic do_start(input logic [5:0] code, input logic rpt);
        @(negedge clk_i);
        key_if.char_code = code;
        key_if.repeat_en = rpt;
        key_if.start     = 1'b1;
        @(negedge clk_i);
        key_if.start     = 1'b0;
    endtask

    // Record outputs on n negedges; poke 1 = start with code 5, poke 2 = drop repeat
    task automatic capture(input int n, input int poke_kind, input int poke_at);
        cap_key.delete();
        cap_busy.delete();
        cap_done.delete();
        for (int i = 0; i < n; i++) begin
            cap_key.push_back(key_if.key_out);
            cap_busy.push_back(key_if.busy);
            cap_done.push_back(key_if.done);
            if (i == poke_at && poke_kind == 1) begin
                key_if.char_code = 6'd5;
                key_if.start     = 1'b1;
            end
            if (i == poke_at + 1 && poke_kind == 1) key_if.start = 1'b0;
            if (i == poke_at && poke_kind == 2) key_if.repeat_en = 1'b0;
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        rst_i            = 1'b1;
        key_if.char_code = 6'd0;
        key_if.start     = 1'b0;
        key_if.repeat_en = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++; if (key_if.key_out !== 1'b0) begin failures++; $display("FAIL rst_key got=%b exp=0", key_if.key_out); end
        checks++; if (key_if.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", key_if.busy); end
        checks++; if (key_if.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", key_if.done); end
        checks++; if (key_if.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", key_if.err); end
        checks++; if (key_if.sym_len !== 3'd0) begin failures++; $display("FAIL rst_sym_len got=%0d exp=0", key_if.sym_len); end
        checks++; if (key_if.pattern !== 6'd0) begin failures++; $display("FAIL rst_pattern got=%b exp=000000", key_if.pattern); end
        rst_i = 1'b0;
    endtask

    task automatic test_e();
        exp_key.delete(); push_seg(1'b1, 4); push_seg(1'b0, 16);
        do_start(6'd5, 1'b0);
        capture(20, 0, -1);
        for (int i = 0; i < 20; i++) begin
            checks++; if (cap_key[i] !== exp_key[i]) begin failures++; $display("FAIL e_key[%0d] got=%b exp=%b", i, cap_key[i], exp_key[i]); end
            checks++; if (cap_busy[i] !== 1'(i < 16)) begin failures++; $display("FAIL e_busy[%0d] got=%b exp=%b", i, cap_busy[i], i < 16); end
            checks++; if (cap_done[i] !== 1'(i == 16)) begin failures++; $display("FAIL e_done[%0d] got=%b exp=%b", i, cap_done[i], i == 16); end
        end
        checks++; if (key_if.sym_len !== 3'd1) begin failures++; $display("FAIL e_sym_len got=%0d exp=1", key_if.sym_len); end
        checks++; if (key_if.pattern !== 6'b000000) begin failures++; $display("FAIL e_pattern got=%b exp=000000", key_if.pattern); end
    endtask

    task automatic test_a();
        exp_key.delete(); push_seg(1'b1, 4); push_seg(1'b0, 4); push_seg(1'b1, 12); push_seg(1'b0, 16);
        do_start(6'd1, 1'b0);
        capture(36, 0, -1);
        for (int i = 0; i < 36; i++) begin
            checks++; if (cap_key[i] !== exp_key[i]) begin failures++; $display("FAIL a_key[%0d] got=%b exp=%b", i, cap_key[i], exp_key[i]); end
            checks++; if (cap_busy[i] !== 1'(i < 32)) begin failures++; $display("FAIL a_busy[%0d] got=%b exp=%b", i, cap_busy[i], i < 32); end
            checks++; if (cap_done[i] !== 1'(i == 32)) begin failures++; $display("FAIL a_done[%0d] got=%b exp=%b", i, cap_done[i], i == 32); end
        end
        checks++; if (key_if.sym_len !== 3'd2) begin failures++; $display("FAIL a_sym_len got=%0d exp=2", key_if.sym_len); end
        checks++; if (key_if.pattern !== 6'b010000) begin failures++; $display("FAIL a_pattern got=%b exp=010000", key_if.pattern); end
    endtask

    task automatic test_zero();
        exp_key.delete();
        for (int s = 0; s < 4; s++) begin push_seg(1'b1, 12); push_seg(1'b0, 4); end
        push_seg(1'b1, 12); push_seg(1'b0, 16);
        do_start(6'd27, 1'b0);
        capture(92, 0, -1);
        for (int i = 0; i < 92; i++) begin
            checks++; if (cap_key[i] !== exp_key[i]) begin failures++; $display("FAIL zero_key[%0d] got=%b exp=%b", i, cap_key[i], exp_key[i]); end
            checks++; if (cap_busy[i] !== 1'(i < 88)) begin failures++; $display("FAIL zero_busy[%0d] got=%b exp=%b", i, cap_busy[i], i < 88); end
            checks++; if (cap_done[i] !== 1'(i == 88)) begin failures++; $display("FAIL zero_done[%0d] got=%b exp=%b", i, cap_done[i], i == 88); end
        end
        checks++; if (key_if.sym_len !== 3'd5) begin failures++; $display("FAIL zero_sym_len got=%0d exp=5", key_if.sym_len); end
        checks++; if (key_if.pattern !== 6'b111110) begin failures++; $display("FAIL zero_pattern got=%b exp=111110", key_if.pattern); end
    endtask

    task automatic test_invalid();
        logic [5:0] codes [2];
        codes[0] = 6'd0;
        codes[1] = 6'd40;
        for (int c = 0; c < 2; c++) begin
            do_start(codes[c], 1'b0);
            checks++; if (key_if.err !== 1'b1) begin failures++; $display("FAIL inv%0d_err got=%b exp=1", codes[c], key_if.err); end
            checks++; if (key_if.busy !== 1'b0) begin failures++; $display("FAIL inv%0d_busy got=%b exp=0", codes[c], key_if.busy); end
            checks++; if (key_if.key_out !== 1'b0) begin failures++; $display("FAIL inv%0d_key got=%b exp=0", codes[c], key_if.key_out); end
            @(negedge clk_i);
            checks++; if (key_if.err !== 1'b0) begin failures++; $display("FAIL inv%0d_err_pulse got=%b exp=0", codes[c], key_if.err); end
            checks++; if (key_if.busy !== 1'b0) begin failures++; $display("FAIL inv%0d_busy2 got=%b exp=0", codes[c], key_if.busy); end
            checks++; if (key_if.pattern !== 6'b111110) begin failures++; $display("FAIL inv%0d_pattern got=%b exp=111110", codes[c], key_if.pattern); end
            checks++; if (key_if.sym_len !== 3'd5) begin failures++; $display("FAIL inv%0d_sym_len got=%0d exp=5", codes[c], key_if.sym_len); end
        end
    endtask

    task automatic test_busy_ignore();
        exp_key.delete(); push_seg(1'b1, 12); push_seg(1'b0, 16);
        do_start(6'd20, 1'b0);
        capture(28, 1, 5);
        for (int i = 0; i < 28; i++) begin
            checks++; if (cap_key[i] !== exp_key[i]) begin failures++; $display("FAIL bsy_key[%0d] got=%b exp=%b", i, cap_key[i], exp_key[i]); end
            checks++; if (cap_busy[i] !== 1'(i < 24)) begin failures++; $display("FAIL bsy_busy[%0d] got=%b exp=%b", i, cap_busy[i], i < 24); end
            checks++; if (cap_done[i] !== 1'(i == 24)) begin failures++; $display("FAIL bsy_done[%0d] got=%b exp=%b", i, cap_done[i], i == 24); end
        end
        checks++; if (key_if.pattern !== 6'b100000) begin failures++; $display("FAIL bsy_pattern got=%b exp=100000", key_if.pattern); end
        checks++; if (key_if.sym_len !== 3'd1) begin failures++; $display("FAIL bsy_sym_len got=%0d exp=1", key_if.sym_len); end
    endtask

    task automatic test_repeat();
        exp_key.delete();
        for (int s = 0; s < 2; s++) begin push_seg(1'b1, 12); push_seg(1'b0, 28); end
        push_seg(1'b1, 12); push_seg(1'b0, 16);
        do_start(6'd20, 1'b1);
        capture(108, 2, 85);
        for (int i = 0; i < 108; i++) begin
            checks++; if (cap_key[i] !== exp_key[i]) begin failures++; $display("FAIL rpt_key[%0d] got=%b exp=%b", i, cap_key[i], exp_key[i]); end
            checks++; if (cap_busy[i] !== 1'(i < 104)) begin failures++; $display("FAIL rpt_busy[%0d] got=%b exp=%b", i, cap_busy[i], i < 104); end
            checks++; if (cap_done[i] !== 1'(i == 104)) begin failures++; $display("FAIL rpt_done[%0d] got=%b exp=%b", i, cap_done[i], i == 104); end
        end
    endtask

    task automatic test_reset_mid();
        do_start(6'd27, 1'b0);
        capture(6, 0, -1);
        checks++; if (key_if.key_out !== 1'b1) begin failures++; $display("FAIL mid_dash_key got=%b exp=1", key_if.key_out); end
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++; if (key_if.key_out !== 1'b0) begin failures++; $display("FAIL mid_rst_key got=%b exp=0", key_if.key_out); end
        checks++; if (key_if.busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", key_if.busy); end
        checks++; if (key_if.done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", key_if.done); end
        checks++; if (key_if.err !== 1'b0) begin failures++; $display("FAIL mid_rst_err got=%b exp=0", key_if.err); end
        checks++; if (key_if.sym_len !== 3'd0) begin failures++; $display("FAIL mid_rst_sym_len got=%0d exp=0", key_if.sym_len); end
        checks++; if (key_if.pattern !== 6'd0) begin failures++; $display("FAIL mid_rst_pattern got=%b exp=000000", key_if.pattern); end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if (key_if.busy !== 1'b0) begin failures++; $display("FAIL mid_post_busy got=%b exp=0", key_if.busy); end
        checks++; if (key_if.key_out !== 1'b0) begin failures++; $display("FAIL mid_post_key got=%b exp=0", key_if.key_out); end
        exp_key.delete(); push_seg(1'b1, 4); push_seg(1'b0, 16);
        do_start(6'd5, 1'b0);
        capture(20, 0, -1);
        for (int i = 0; i < 20; i++) begin
            checks++; if (cap_key[i] !== exp_key[i]) begin failures++; $display("FAIL mid_e_key[%0d] got=%b exp=%b", i, cap_key[i], exp_key[i]); end
            checks++; if (cap_done[i] !== 1'(i == 16)) begin failures++; $display("FAIL mid_e_done[%0d] got=%b exp=%b", i, cap_done[i], i == 16); end
        end
    endtask

    initial begin
        test_reset();
        test_e();
        test_a();
        test_zero();
        test_invalid();
        test_busy_ignore();
        test_repeat();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/morse_keyer.md
# morse_keyer

Sequential successor to the combinational Morse lookup. It latches a 6-bit character code and serialises the standard ITU Morse pattern onto a single key line with correct dot/dash/gap timing. The unit duration is parametrised, and an optional repeat mode re-keys the character continuously. It sits between the switch/character source and the LED/buzzer driver on the Basys3 top level.

## Interface
- UNIT_CYCLES, 12_500_000: clock cycles per Morse time unit (125 ms at 100 MHz); must be ≥ 1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- char_code  in  6  character select:
  - 1–26 = A–Z
  - 27–36 = digits 0–9
  - 37 = '.', 38 = ',', 39 = '?'
  - 0 and 40–63 are invalid.
- start  in  1  request to key char_code; sampled only in IDLE.
- repeat  in  1  level; when high at the end of a character, the same latched character is re-keyed after a word gap.
- key_out  out  1  registered; 1 = mark (tone/LED on).
- busy  out  1  high from the cycle after start is accepted until keying completes.
- done  out  1  one-cycle pulse on completion.
- err  out  1  one-cycle pulse when start is sampled with an invalid code.
- sym_len  out  3  symbol count (1–6) of the latched character; 0 after reset.
- pattern  out  6  latched pattern, MSB-first; 1 = dash, unused low bits 0. This matches the existing LED encoding, e.g. '0' = 111110 and '.' = 010101.

## Operation
- Internal ROM maps char_code to {pattern, length} per standard ITU Morse.
- Timing rules, in units:
  - dot = 1 unit mark; dash = 3 units mark.
  - intra-character gap = 1 unit space.
  - inter-character gap = 3 units space.
  - repeat word gap = 7 units space in total.
- FSM states:
  - IDLE: start=1 with valid code → latch pattern/sym_len, load symbol index 0, enter MARK. Invalid code → err=1 for one cycle, stay in IDLE, pattern/sym_len unchanged.
  - MARK: key_out=1 for 1 or 3 units according to the current pattern bit. Then go to SPACE if symbols remain, else CGAP.
  - SPACE: key_out=0 for 1 unit, advance index, go to MARK.
  - CGAP: key_out=0 for 3 units. At the end, if repeat=1 go to WGAP; else go to IDLE with done=1.
  - WGAP: key_out=0 for 4 more units, then go to MARK at index 0 with the same latched character. char_code is not resampled.
- Unit counter: width $clog2(UNIT_CYCLES+1); counts 0..UNIT_CYCLES-1. A units counter (0..3) counts units within a state.
- start while busy is ignored; no queuing.
- repeat dropping mid-character lets the current character finish normally, then done pulses.
- rst at any time: next edge forces IDLE and clears all outputs.

## Timing
- Reset values: key_out=0, busy=0, done=0, err=0, sym_len=0, pattern=0.
- Start sampled at edge E0 → key_out=1 and busy=1 from E0 (first high cycle follows E0). Latency is 1 cycle.
- Total busy time for a non-repeat character: U·(Σmark units + (n−1) + 3), where U = UNIT_CYCLES.
- done is high in the first cycle busy is 0. A new start is accepted in that same cycle.
- err asserts in the cycle after the invalid start is sampled; busy stays 0.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst for 3 cycles mid-dash with U=4 → key_out=0 on the next edge; all outputs 0; the FSM accepts a new start afterwards.
- 'E' (code 5), U=4: key_out high for 4 cycles, then low for 12. busy is high for 16 cycles; done pulses once on cycle 17. sym_len=1, pattern=000000.
- 'A' (code 1), U=4:
  - key_out: high 4, low 4, high 12, low 12; busy for 32 cycles.
  - Expected outputs: pattern=010000, sym_len=2.
- '0' (code 27), U=4:
  - key_out: five 12-cycle marks separated by 4-cycle spaces, then 12 cycles low; busy for 88 cycles.
  - Expected outputs: pattern=111110, sym_len=5.
- Invalid codes 0 and 40: err pulses for 1 cycle, busy stays 0, key_out stays 0. Then start with code 20 while busy, switching char_code to 5 mid-keying → the change is ignored and 'T' completes (12 on, 12 off).
- Repeat 'T' (code 20), U=4, repeat=1: key_out pattern is 12 on, 28 off, repeating with no done pulses. Drop repeat during a mark → that mark completes, then 12 off, then a single done pulse.
